seg_memory: RTL
===============

SEG_MEMORY -- requirements
Module: seg_memory

Interface
REQ-001 The block SHALL have parameter NB_ADDR, default 32, PC/branch-target width.
REQ-002 The block SHALL have parameter NB_DATA, default 32, data word width.
REQ-003 The block SHALL have parameter NB_REG, default 5, register-specifier width.
REQ-004 The block SHALL have parameter NB_CTRL_WB, default 2, write-back control width {RegWrite, MemtoReg}.
REQ-005 The block SHALL have parameter NB_CTRL_M, default 3, memory control width {Branch, MemRead, MemWrite}, MSB first.
REQ-006 The block SHALL have parameter NB_MEM_ADDR, default 8, word-address width (2^8 = 256 words).
REQ-007 The block SHALL have port i_clk, input, 1 bit, the only clock; all state updates on its rising edge.
REQ-008 The block SHALL have port i_rst, input, 1 bit, reset; synchronous, active-low.
REQ-009 The block SHALL have port i_PC, input, NB_ADDR bits, branch target from the execute stage.
REQ-010 The block SHALL have port i_ALU_result, input, NB_DATA bits, byte address or ALU value.
REQ-011 The block SHALL have port i_ALU_zero, input, 1 bit, ALU zero flag.
REQ-012 The block SHALL have port i_read_data_2, input, NB_DATA bits, store data.
REQ-013 The block SHALL have port i_instruction_20_16_o_15_11, input, NB_REG bits, destination register.
REQ-014 The block SHALL have port i_control, input, NB_CTRL_WB+NB_CTRL_M bits; [4:3] = WB, [2:0] = M.
REQ-015 The block SHALL have port o_PC, output, NB_ADDR bits, branch target to fetch, combinational pass-through of i_PC.
REQ-016 The block SHALL have port o_PCSrc, output, 1 bit, branch taken, combinational.
REQ-017 The block SHALL have port o_read_data, output, NB_DATA bits, registered load data.
REQ-018 The block SHALL have port o_ALU_result, output, NB_DATA bits, registered copy of i_ALU_result.
REQ-019 The block SHALL have port o_write_reg, output, NB_REG bits, registered destination register.
REQ-020 The block SHALL have port o_control, output, NB_CTRL_WB bits, registered WB control.
REQ-021 The block SHALL have port o_misaligned, output, 1 bit, registered misaligned-access flag.

Function
REQ-022 o_PCSrc SHALL equal Branch AND i_ALU_zero, with no register.
REQ-023 Data memory SHALL be 2^NB_MEM_ADDR words of NB_DATA bits, word index = i_ALU_result[NB_MEM_ADDR+1:2]; upper address bits are ignored (wrap-around).
REQ-024 An access SHALL be misaligned when (MemRead OR MemWrite) is set and i_ALU_result[1:0] != 0.
REQ-025 When MemWrite is set, i_rst is high, and the access is aligned, mem[index] SHALL take i_read_data_2 at the clock edge.
REQ-026 Misaligned writes SHALL be suppressed, leaving memory unchanged.
REQ-027 When MemRead is set and the access is aligned, o_read_data SHALL take mem[index] one cycle later; otherwise o_read_data SHALL take 0.
REQ-028 When MemRead and MemWrite are both set on an aligned access, the write SHALL occur and o_read_data SHALL return the pre-write contents (read-before-write).
REQ-029 o_ALU_result, o_write_reg, o_control and o_misaligned SHALL register their inputs every cycle; latency is exactly 1 cycle, with no stall and no enable.
REQ-030 On a misaligned access, o_control[1] (RegWrite) SHALL be forced to 0 in the registered output, and o_misaligned SHALL be 1 for that cycle.
REQ-031 A load in cycle N followed by a store in cycle N+1 to the same word SHALL yield the old data for the load.
REQ-032 A store in cycle N followed by a load in cycle N+1 to the same word SHALL yield the new data for the load.

Reset
REQ-033 While i_rst = 0 at a clock edge, o_read_data, o_ALU_result, o_write_reg, o_control and o_misaligned SHALL become 0.
REQ-034 While i_rst = 0 at a clock edge, all memory words SHALL be cleared to 0, and no write from inputs SHALL occur.
REQ-035 Reset asserted mid-operation SHALL discard the in-flight access, and the first cycle after release SHALL operate normally.
REQ-036 o_PC and o_PCSrc SHALL remain combinational and unaffected by reset.

Verification
REQ-037 The bench SHALL drive reset low for 2 cycles, then release; the required response is all registered outputs = 0 and a load from address 0x0 returning 0x00000000.
REQ-038 The bench SHALL store 0xDEADBEEF to 0x10, then load 0x10 in the next cycle; the required response is o_read_data = 0xDEADBEEF one cycle after the load.
REQ-039 The bench SHALL drive Branch = 1 with i_ALU_zero = 1, then i_ALU_zero = 0, with i_PC = 0x40; the required response is o_PC = 0x40 and o_PCSrc = 1, then o_PCSrc = 0, in the same cycle.
REQ-040 The bench SHALL issue a store to 0x13 with data 0x12345678, then load 0x10; the required response is o_misaligned = 1 and RegWrite forced to 0 for the store, and the load returning the prior contents (0 after reset).
REQ-041 The bench SHALL store 0xCAFEF00D to 0x404, then load 0x004; the required response is 0xCAFEF00D (wrap-around).
REQ-042 The bench SHALL assert reset while MemWrite is active to 0x20 with data 0x55AA55AA, then release and load 0x20; the required response is 0x00000000.

Source files
------------

// File: rtl/seg_memory.sv
// seg_memory: MEM stage of a 5-stage pipeline.
// It holds a word-addressed data memory and resolves the branch.
// It also registers the values that the WB stage needs.
module seg_memory #(
  parameter int NB_ADDR     = 32,
  parameter int NB_DATA     = 32,
  parameter int NB_REG      = 5,
  parameter int NB_CTRL_WB  = 2,
  parameter int NB_CTRL_M   = 3,
  parameter int NB_MEM_ADDR = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NB_ADDR-1:0]             i_PC,
  input  logic [NB_DATA-1:0]             i_ALU_result,
  input  logic                           i_ALU_zero,
  input  logic [NB_DATA-1:0]             i_read_data_2,
  input  logic [NB_REG-1:0]              i_instruction_20_16_o_15_11,
  input  logic [NB_CTRL_WB+NB_CTRL_M-1:0] i_control,
  output logic [NB_ADDR-1:0]             o_PC,
  output logic                           o_PCSrc,
  output logic [NB_DATA-1:0]             o_read_data,
  output logic [NB_DATA-1:0]             o_ALU_result,
  output logic [NB_REG-1:0]              o_write_reg,
  output logic [NB_CTRL_WB-1:0]          o_control,
  output logic                           o_misaligned
);

  localparam int NB_CTRL = NB_CTRL_WB + NB_CTRL_M;
  localparam int DEPTH   = 2**NB_MEM_ADDR;

  // Decode the control field: {WB[RegWrite,MemtoReg], M[Branch,MemRead,MemWrite]}.
  logic [NB_CTRL_WB-1:0]  wb_ctrl;
  logic                   branch, mem_read, mem_write;
  logic                   misaligned, wr_en;
  logic [NB_MEM_ADDR-1:0] idx;

  assign wb_ctrl    = i_control[NB_CTRL-1:NB_CTRL_M];
  assign branch     = i_control[NB_CTRL_M-1];
  assign mem_read   = i_control[NB_CTRL_M-2];
  assign mem_write  = i_control[NB_CTRL_M-3];
  // The upper address bits are dropped, so addresses wrap modulo the memory size.
  assign idx        = i_ALU_result[NB_MEM_ADDR+1:2];
  assign misaligned = (mem_read | mem_write) && (i_ALU_result[1:0] != 2'b00);
  assign wr_en      = mem_write & ~misaligned;

  // The branch decision feeds fetch in the same cycle, so it is not registered.
  assign o_PC    = i_PC;
  assign o_PCSrc = branch & i_ALU_zero;

  logic [NB_DATA-1:0]    mem_q [DEPTH];
  logic [NB_DATA-1:0]    read_data_q, read_data_d;
  logic [NB_DATA-1:0]    alu_q, alu_d;
  logic [NB_REG-1:0]     write_reg_q, write_reg_d;
  logic [NB_CTRL_WB-1:0] control_q, control_d;
  logic                  mis_q, mis_d;

  // Next-state values for the MEM/WB register.
  // The memory read returns the word from before this cycle's write.
  always_comb begin
    read_data_d = '0;
    alu_d       = i_ALU_result;
    write_reg_d = i_instruction_20_16_o_15_11;
    control_d   = wb_ctrl;
    mis_d       = misaligned;
    if (mem_read && !misaligned) read_data_d = mem_q[idx];
    // A faulting access must not write back to the register file.
    if (misaligned) control_d[NB_CTRL_WB-1] = 1'b0;
  end

  // MEM/WB pipeline register. It loads every cycle and is cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      read_data_q <= '0;
      alu_q       <= '0;
      write_reg_q <= '0;
      control_q   <= '0;
      mis_q       <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      alu_q       <= alu_d;
      write_reg_q <= write_reg_d;
      control_q   <= control_d;
      mis_q       <= mis_d;
    end
  end

  // Data memory. Reset clears every word and blocks any pending store.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= i_read_data_2;
    end
  end

  assign o_read_data  = read_data_q;
  assign o_ALU_result = alu_q;
  assign o_write_reg  = write_reg_q;
  assign o_control    = control_q;
  assign o_misaligned = mis_q;

endmodule
